alu_div: RTL and testbench
==========================

ALU_DIV -- requirements
Module: alu_div

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high; forces the reset state immediately, independent of clk.
REQ-004 start  input  1  request; an operation is accepted on a rising edge where start=1 and ready=1.
REQ-005 A  input  32  dividend; sampled only at acceptance.
REQ-006 B  input  32  divisor; sampled only at acceptance.
REQ-007 F  input  2  operation, sampled at acceptance. 00 = DIV (signed quotient), 01 = DIVU, 10 = REM (signed remainder), 11 = REMU.
REQ-008 flush  input  1  synchronous abort of any in-flight operation.
REQ-009 ready  output  1  high only in state IDLE.
REQ-010 valid  output  1  registered; high for exactly one cycle per completed operation.
REQ-011 Y  output  32  registered result; holds its value until the next completion or reset.
REQ-012 Zero  output  1  combinational (Y == 0), valid at all times.

Function
REQ-013 The block SHALL implement the states IDLE, BUSY, FIX and DONE.
REQ-014 Transitions SHALL be as follows.
- IDLE -> BUSY on acceptance.
- BUSY -> FIX after 32 iteration edges.
- FIX -> DONE on the next edge.
- DONE -> IDLE on the next edge.
REQ-015 At acceptance (edge e0), the block SHALL capture the following.
- Operand magnitudes: |A| and |B| for signed ops; raw values for unsigned ops.
- Sign flags: qneg = A[31]^B[31] and rneg = A[31] for signed ops; both 0 for unsigned ops.
- F, a divide-by-zero flag (B == 0) and an overflow flag (signed op with A = 0x80000000 and B = 0xFFFFFFFF).
REQ-016 BUSY SHALL perform one restoring shift-subtract step per edge (e1..e32), producing one quotient bit per edge, MSB first, using a 33-bit partial remainder; a 6-bit iteration counter SHALL terminate BUSY.
REQ-017 At edge e33 (FIX -> DONE), the block SHALL write the following.
- Y = quotient, negated if qneg (DIV/DIVU), or remainder, negated if rneg (REM/REMU).
- valid = 1.
REQ-018 valid SHALL be 1 only in the cycle between e33 and e34, and ready SHALL return to 1 at e34, giving a fixed latency of 33 cycles and an initiation interval of 34 cycles.
REQ-019 Latency SHALL be fixed for all operand values, including the special cases in REQ-020 and REQ-021.
REQ-020 Divide by zero SHALL produce the following, with no exception signalled.
- DIV and DIVU: Y = 0xFFFFFFFF.
- REM and REMU: Y = the original A.
REQ-021 Signed overflow SHALL produce the following.
- DIV: Y = 0x80000000.
- REM: Y = 0x00000000.
REQ-022 start while ready = 0 SHALL be ignored; A, B and F changes outside acceptance SHALL have no effect.
REQ-023 flush = 1 on any edge SHALL force IDLE and valid = 0 at that edge, and Y SHALL keep its previous value.
REQ-024 flush SHALL take priority over start on the same edge, so no operation is accepted.
REQ-025 flush in DONE SHALL clear valid at that edge; the result in Y is retained.
REQ-026 All arithmetic SHALL be two's complement modulo 2^32, and the magnitude of 0x80000000 SHALL be treated as unsigned 2^31.

Reset
REQ-027 While reset = 1, the block SHALL hold: state = IDLE, ready = 1, valid = 0, Y = 0x00000000, Zero = 1, iteration counter = 0, internal operand and remainder registers = 0.
REQ-028 Reset asserted mid-operation SHALL discard the operation; no valid pulse SHALL follow, and the first start accepted after reset deassertion SHALL complete normally.

Verification
REQ-029 DIVU: A = 100, B = 7, F = 01 -> valid exactly 33 cycles after acceptance, Y = 14. Then REMU with the same operands -> Y = 2. ready low for 34 cycles per operation.
REQ-030 Signed: A = 0xFFFFFFF9 (-7), B = 2. DIV -> Y = 0xFFFFFFFD. REM -> Y = 0xFFFFFFFF. With A = 7, B = 0xFFFFFFFE: DIV -> Y = 0xFFFFFFFD and REM -> Y = 1.
REQ-031 Divide by zero: A = 5, B = 0. DIVU and DIV -> Y = 0xFFFFFFFF. REMU and REM -> Y = 5. Latency is still 33 cycles.
REQ-032 Overflow: A = 0x80000000, B = 0xFFFFFFFF. DIV -> Y = 0x80000000. REM -> Y = 0, Zero = 1.
REQ-033 Flush and ignored start:
- Accept DIVU 1000/10, assert start again at cycle 5 (ignored), flush at cycle 10 -> no valid, ready = 1 next cycle.
- Then accept DIVU 9/3 -> Y = 3 after 33 cycles.
- start and flush asserted together -> not accepted.
REQ-034 Asynchronous reset at cycle 20 of an operation -> immediately ready = 1, valid = 0, Y = 0, Zero = 1, with no later valid pulse; the next operation then completes correctly.

Source files
------------

// File: rtl/alu_div.sv
// 32-bit iterative divider covering DIV/DIVU/REM/REMU.
// Restoring shift-subtract, one quotient bit per clock, fixed 33-cycle latency.
module alu_div (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [1:0]  F,
  input  logic        flush,
  output logic        ready,
  output logic        valid,
  output logic [31:0] Y,
  output logic        Zero
);

  localparam int unsigned W  = 32;
  localparam int unsigned RW = W + 1;
  localparam int unsigned SW = W + 2;
  localparam int unsigned CW = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state;
  state_t next_state;

  logic [CW-1:0] cnt;
  logic [W-1:0]  quo;
  logic [W-1:0]  dvs;
  logic [RW-1:0] rem;
  logic [W-1:0]  a_orig;
  logic [1:0]    op;
  logic          qneg;
  logic          rneg;
  logic          dz;
  logic          ovf;

  logic          ready_d;
  logic          valid_d;
  logic          accept;
  logic          step;
  logic          load_y;

  // Operand conditioning at acceptance; F[0]=1 selects unsigned, F[1]=1 selects remainder.
  logic          signed_op;
  logic [W-1:0]  a_mag;
  logic [W-1:0]  b_mag;
  logic          dz_in;
  logic          ovf_in;

  always_comb begin
    signed_op = ~F[0];
    a_mag     = (signed_op && A[W-1]) ? W'(-A) : A;
    b_mag     = (signed_op && B[W-1]) ? W'(-B) : B;
    dz_in     = (B == '0);
    ovf_in    = signed_op && (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  logic [SW-1:0] shifted;
  logic [SW-1:0] trial;
  logic          fits;
  logic [RW-1:0] rem_next;

  always_comb begin
    shifted  = {rem, quo[W-1]};
    trial    = shifted - {2'b00, dvs};
    fits     = (shifted >= {2'b00, dvs});
    rem_next = fits ? RW'(trial) : RW'(shifted);
  end

  // Final sign fix-up and special-case selection.
  logic [W-1:0] q_fix;
  logic [W-1:0] r_fix;
  logic [W-1:0] result;

  always_comb begin
    q_fix = qneg ? W'(-quo) : quo;
    r_fix = rneg ? W'(-rem[W-1:0]) : rem[W-1:0];
    if (dz) begin
      result = op[1] ? a_orig : 32'hFFFF_FFFF;
    end else if (ovf) begin
      result = op[1] ? 32'h0000_0000 : 32'h8000_0000;
    end else begin
      result = op[1] ? r_fix : q_fix;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; flush overrides everything, including a same-edge start.
  always_comb begin
    next_state = state;
    if (flush) begin
      next_state = IDLE;
    end else begin
      unique case (state)
        IDLE: if (start) next_state = BUSY;
        BUSY: if (cnt == CW'(W - 1)) next_state = FIX;
        FIX:  next_state = DONE;
        DONE: next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Output/control decode.
  always_comb begin
    ready_d = (next_state == IDLE);
    valid_d = (next_state == DONE);
    accept  = (state == IDLE) && (next_state == BUSY);
    step    = (state == BUSY) && !flush;
    load_y  = (state == FIX) && (next_state == DONE);
  end

  // Registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready <= 1'b1;
      valid <= 1'b0;
    end else begin
      ready <= ready_d;
      valid <= valid_d;
    end
  end

  // Datapath: operand capture and iteration.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      quo    <= '0;
      dvs    <= '0;
      rem    <= '0;
      a_orig <= '0;
      op     <= '0;
      qneg   <= 1'b0;
      rneg   <= 1'b0;
      dz     <= 1'b0;
      ovf    <= 1'b0;
    end else if (accept) begin
      cnt    <= '0;
      quo    <= a_mag;
      dvs    <= b_mag;
      rem    <= '0;
      a_orig <= A;
      op     <= F;
      qneg   <= signed_op & (A[W-1] ^ B[W-1]);
      rneg   <= signed_op & A[W-1];
      dz     <= dz_in;
      ovf    <= ovf_in;
    end else if (step) begin
      cnt    <= cnt + CW'(1);
      quo    <= {quo[W-2:0], fits};
      rem    <= rem_next;
    end
  end

  // Result register holds until the next completion or reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Y <= '0;
    end else if (load_y) begin
      Y <= result;
    end
  end

  assign Zero = (Y == '0);

endmodule

// File: tb/tb_alu_div.sv
// Randomized and directed bench for alu_div against an arithmetic reference model.
module tb_alu_div;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic [1:0]  F;
  logic        flush;
  logic        ready;
  logic        valid;
  logic [31:0] Y;
  logic        Zero;

  int n_vec;
  int n_err;
  logic [31:0] last_y;

  alu_div dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (A),
    .B     (B),
    .F     (F),
    .flush (flush),
    .ready (ready),
    .valid (valid),
    .Y     (Y),
    .Zero  (Zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain signed/unsigned arithmetic with the architectural special cases.
  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa;
    longint sb;
    longint ua;
    longint ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
    case (op)
      2'b00:   return 32'(sa / sb);
      2'b01:   return 32'(ua / ub);
      2'b10:   return 32'(sa % sb);
      default: return 32'(ua % ub);
    endcase
  endfunction

  // Runs one operation from acceptance to completion; call #1 after a rising edge.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp;
    int lat;
    bit seen;
    bit ready_leak;
    exp = ref_res(op, a, b);
    check("ready_before", 32'(ready), 32'd1);
    start = 1'b1;
    A = a;
    B = b;
    F = op;
    @(posedge clk); #1;
    start = 1'b0;
    A = $urandom;
    B = $urandom;
    F = 2'($urandom);
    check("busy_ready", 32'(ready), 32'd0);
    lat = 0;
    seen = 1'b0;
    ready_leak = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 5) begin
        start = 1'b1;
        A = $urandom;
        B = $urandom;
      end
      if (lat == 6) start = 1'b0;
      if (valid) seen = 1'b1;
      if (ready) ready_leak = 1'b1;
    end
    check("latency", 32'(lat), 32'd33);
    check("ready_low", 32'(ready_leak), 32'd0);
    check("Y", Y, exp);
    check("Zero", 32'(Zero), 32'(exp == 32'h0));
    @(posedge clk); #1;
    check("valid_pulse", 32'(valid), 32'd0);
    check("ready_back", 32'(ready), 32'd1);
    check("Y_hold", Y, exp);
    last_y = exp;
  endtask

  // Watches for any stray valid pulse over a window of cycles.
  task automatic expect_quiet(input string tag, input int cycles);
    bit any;
    any = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (valid) any = 1'b1;
    end
    check(tag, 32'(any), 32'd0);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    n_vec = 0;
    n_err = 0;
    last_y = 32'h0;
    reset = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    A = 32'h0;
    B = 32'h0;
    F = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_Y", Y, 32'h0);
    check("rst_Zero", 32'(Zero), 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    run_op(2'b01, 32'd100, 32'd7);
    check("divu_100_7", Y, 32'd14);
    run_op(2'b11, 32'd100, 32'd7);
    check("remu_100_7", Y, 32'd2);
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2);
    check("div_m7_2", Y, 32'hFFFF_FFFD);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    check("rem_m7_2", Y, 32'hFFFF_FFFF);
    run_op(2'b00, 32'd7, 32'hFFFF_FFFE);
    check("div_7_m2", Y, 32'hFFFF_FFFD);
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE);
    check("rem_7_m2", Y, 32'd1);
    run_op(2'b01, 32'd5, 32'd0);
    check("divu_dz", Y, 32'hFFFF_FFFF);
    run_op(2'b00, 32'd5, 32'd0);
    check("div_dz", Y, 32'hFFFF_FFFF);
    run_op(2'b11, 32'd5, 32'd0);
    check("remu_dz", Y, 32'd5);
    run_op(2'b10, 32'd5, 32'd0);
    check("rem_dz", Y, 32'd5);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf", Y, 32'h8000_0000);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    check("rem_ovf", Y, 32'h0);
    check("rem_ovf_zero", 32'(Zero), 32'd1);

    // Flush mid-operation
    start = 1'b1;
    A = 32'd1000;
    B = 32'd10;
    F = 2'b01;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (i == 5) start = 1'b1;
      if (i == 6) start = 1'b0;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_ready", 32'(ready), 32'd1);
    check("flush_valid", 32'(valid), 32'd0);
    check("flush_Y", Y, last_y);
    expect_quiet("flush_quiet", 40);
    run_op(2'b01, 32'd9, 32'd3);
    check("divu_9_3", Y, 32'd3);

    // start together with flush is not accepted
    start = 1'b1;
    flush = 1'b1;
    A = 32'd50;
    B = 32'd5;
    F = 2'b01;
    @(posedge clk); #1;
    start = 1'b0;
    flush = 1'b0;
    check("sf_ready", 32'(ready), 32'd1);
    expect_quiet("sf_quiet", 36);
    check("sf_Y", Y, last_y);

    // Asynchronous reset mid-operation
    start = 1'b1;
    A = 32'd123456;
    B = 32'd789;
    F = 2'b01;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("arst_ready", 32'(ready), 32'd1);
    check("arst_valid", 32'(valid), 32'd0);
    check("arst_Y", Y, 32'h0);
    check("arst_Zero", 32'(Zero), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    last_y = 32'h0;
    expect_quiet("arst_quiet", 40);
    run_op(2'b00, 32'hFFFF_FF00, 32'd16);
    check("arst_next", Y, 32'hFFFF_FFF0);

    // Randomized operations with biased special operands
    for (int n = 0; n < 40; n++) begin
      rop = 2'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = $urandom_range(1, 15);
        3: rb = 32'(-$urandom_range(1, 15));
        4: ra = $urandom_range(0, 100);
        default: ;
      endcase
      run_op(rop, ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
